// File: rtl/binary_to_bcd_pkg.sv
// Shared types and constants for the binary_to_bcd converter.
package binary_to_bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t  BCD_ADD3_THRESH = 4'd5;
  localparam int unsigned BCD_MAX_IN_W    = 6;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 before the next shift.
module bcd_add3
  import binary_to_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = din;
    if (din >= BCD_ADD3_THRESH) dout = din + 4'd3;
  end
endmodule

// File: rtl/binary_to_bcd.sv
// Unsigned binary to two-digit BCD, fully unrolled shift-add-3.
// Define BINARY_TO_BCD_REG_EN to add the registered copy with out_valid strobe.
module binary_to_bcd
  import binary_to_bcd_pkg::*;
#(
  parameter int unsigned IN_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] binary_input,
  input  logic            in_valid,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic [3:0]      tens_q,
  output logic [3:0]      ones_q,
  output logic            out_valid
);
  if (IN_W < 1 || IN_W > BCD_MAX_IN_W) begin : g_bad_in_w
    $error("binary_to_bcd: IN_W=%0d outside 1..%0d", IN_W, BCD_MAX_IN_W);
  end

  // stage[i] holds {tens, ones} after i shifts
  logic [7:0]      stage [IN_W+1];
  logic [IN_W-1:0] unused_carry;

  assign stage[0] = '0;

  for (genvar i = 0; i < IN_W; i++) begin : g_stage
    bcd_digit_t ones_c;
    bcd_digit_t tens_c;

    bcd_add3 u_ones (.din(stage[i][3:0]), .dout(ones_c));
    bcd_add3 u_tens (.din(stage[i][7:4]), .dout(tens_c));

    // tens never reaches 8 for inputs up to 63, so its MSB shifted out is always 0
    assign stage[i+1]      = {tens_c[2:0], ones_c, binary_input[IN_W-1-i]};
    assign unused_carry[i] = tens_c[3];
  end

  assign tens = stage[IN_W][7:4];
  assign ones = stage[IN_W][3:0];

`ifdef BINARY_TO_BCD_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q    <= '0;
      ones_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        tens_q <= tens;
        ones_q <= ones;
      end
    end
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = ^{clk, rst_n, in_valid};
  assign tens_q      = '0;
  assign ones_q      = '0;
  assign out_valid   = 1'b0;
`endif
endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd; the registered-path expectations follow BINARY_TO_BCD_REG_EN.
module tb_binary_to_bcd;
  localparam int unsigned IN_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IN_W-1:0] binary_input;
  logic            in_valid;
  logic [3:0]      tens, ones, tens_q, ones_q;
  logic            out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  logic [7:0] last_reg = '0;

  binary_to_bcd #(.IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .binary_input(binary_input), .in_valid(in_valid),
    .tens(tens), .ones(ones), .tens_q(tens_q), .ones_q(ones_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_bcd(input int v);
    int t, o;
    t = v / 10;
    o = v % 10;
    return {t[3:0], o[3:0]};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input logic vld);
    @(negedge clk);
    binary_input = v[IN_W-1:0];
    in_valid     = vld;
`ifdef BINARY_TO_BCD_REG_EN
    if (vld) exp_q.push_back(ref_bcd(v));
`endif
  endtask

  // Monitor: samples 1 ns after each rising edge
  always @(posedge clk) begin
    #1;
`ifdef BINARY_TO_BCD_REG_EN
    if (!rst_n) begin
      chk("reg_in_reset", {out_valid, tens_q, ones_q}, 9'h0);
      last_reg = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_valid: got %0h/%0h with nothing expected", tens_q, ones_q);
      end else begin
        last_reg = exp_q.pop_front();
        chk("reg_data", {tens_q, ones_q}, last_reg);
      end
    end else begin
      chk("reg_hold", {tens_q, ones_q}, last_reg);
    end
`else
    chk("reg_tied_off", {out_valid, tens_q, ones_q}, 9'h0);
`endif
  end

  initial begin
    int sweep_ok;
    int bnd_in [8] = '{0, 9, 10, 19, 20, 29, 30, 31};
    logic [7:0] bnd_out [8] = '{8'h00, 8'h09, 8'h10, 8'h19, 8'h20, 8'h29, 8'h30, 8'h31};

    rst_n = 1'b0;
    in_valid = 1'b0;
    binary_input = '0;

    // Exhaustive combinational sweep, held in reset to show independence from it
    sweep_ok = 0;
    for (int v = 0; v < 32; v++) begin
      binary_input = v[IN_W-1:0];
      #10;
      chk("sweep", {tens, ones}, ref_bcd(v));
      if ({tens, ones} === ref_bcd(v)) sweep_ok++;
    end
    $display("%0d of 32 tests passed", sweep_ok);

    for (int k = 0; k < 8; k++) begin
      binary_input = bnd_in[k][IN_W-1:0];
      #10;
      chk("boundary", {tens, ones}, bnd_out[k]);
    end

    binary_input = 5'd27;
    #10;
    chk("reset_comb", {tens, ones}, 8'h27);
    chk("reset_reg", {out_valid, tens_q, ones_q}, 9'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Single capture: nothing changes before the edge
    drive(17, 1'b1);
    #4;
    chk("before_edge", {out_valid, tens_q, ones_q}, 9'h0);
    drive(0, 1'b0);

    // Back-to-back stream then idle
    drive(5, 1'b1);
    drive(23, 1'b1);
    drive(31, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b0);
`ifdef BINARY_TO_BCD_REG_EN
    chk("stream_hold", {out_valid, tens_q, ones_q}, 9'h031);
`else
    chk("stream_hold", {out_valid, tens_q, ones_q}, 9'h000);
`endif

    for (int c = 0; c < 200; c++)
      drive(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    drive(0, 1'b0);

    // Asynchronous reset between edges while out_valid is high
    drive(12, 1'b1);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, tens_q, ones_q}, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(28, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
